// File: rtl/rf_pkg.sv
// Shared constants and helpers for the pipelined register file.
// Imported by the register file, its scoreboard and its interface users.
package rf_pkg;

   localparam int DEF_DW   = 32;
   localparam int DEF_NREG = 32;
   localparam int ZERO_REG = 0;

   // Widest packed port bus the slice helper handles (4 ports x 64 bits).
   localparam int MAXBUS   = 256;

   // Returns field k of width w from a packed multi-port bus, zero-extended.
   function automatic logic [MAXBUS-1:0] port_slice(
      input logic [MAXBUS-1:0] bus,
      input int                k,
      input int                w
   );
      logic [MAXBUS-1:0] mask;
      mask = (MAXBUS'(1) << w) - MAXBUS'(1);
      return (bus >> (k * w)) & mask;
   endfunction

endpackage

// File: rtl/regfile_fwd_if.sv
// Decode/writeback bundle for the forwarding register file.
// Master is the pipeline side, slave is the register file.
interface regfile_fwd_if #(
   parameter int DW  = 32,
   parameter int AW  = 5,
   parameter int NRD = 2
);

   logic [NRD*AW-1:0] raddr;
   logic [NRD-1:0]    ren;
   logic [NRD*DW-1:0] rdata;
   logic [NRD-1:0]    rbusy;
   logic              hazard;
   logic              we;
   logic [AW-1:0]     waddr;
   logic [DW-1:0]     wdata;
   logic              iss_valid;
   logic [AW-1:0]     iss_addr;

   modport master (
      output raddr, ren, we, waddr, wdata, iss_valid, iss_addr,
      input  rdata, rbusy, hazard
   );

   modport slave (
      input  raddr, ren, we, waddr, wdata, iss_valid, iss_addr,
      output rdata, rbusy, hazard
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits tracking outstanding producers.
// An issue and a retire to the same register in one cycle leaves it busy.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter  int NREG = DEF_NREG,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set_en,
   input  logic [AW-1:0]   set_addr,
   input  logic            clr_en,
   input  logic [AW-1:0]   clr_addr,
   output logic [NREG-1:0] busy
);

   logic [NREG-1:0] busy_nxt;

   // Next busy vector: retire first, then a new issue overrides it.
   always_comb begin
      busy_nxt = busy;
      if (clr_en && (clr_addr != AW'(ZERO_REG)))
         busy_nxt[clr_addr] = 1'b0;
      if (set_en && (set_addr != AW'(ZERO_REG)))
         busy_nxt[set_addr] = 1'b1;
      busy_nxt[ZERO_REG] = 1'b0;
   end

   // Busy vector register, cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

endmodule

// File: rtl/regfile_fwd.sv
// Multi-port register file with write-to-read forwarding and RAW scoreboard.
// Register 0 is hardwired to zero and never becomes busy.
module regfile_fwd
   import rf_pkg::*;
#(
   parameter  int DW   = DEF_DW,
   parameter  int NREG = DEF_NREG,
   parameter  int NRD  = 2,
   parameter  int FWD  = 1,
   localparam int AW   = $clog2(NREG)
) (
   input  logic         clk,
   input  logic         rst,
   regfile_fwd_if.slave rf
);

   logic [DW-1:0]     mem [NREG];
   logic [NREG-1:0]   busy;
   logic [AW-1:0]     ra [NRD];
   logic [NRD-1:0]    fwd_hit;
   logic [NRD-1:0]    reiss;
   logic [NRD*DW-1:0] rdata_c;
   logic [NRD-1:0]    rbusy_c;
   logic              wr_ok;

   assign wr_ok = rf.we && (rf.waddr != AW'(ZERO_REG));

   rf_scoreboard #(
      .NREG (NREG)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (rf.iss_valid),
      .set_addr (rf.iss_addr),
      .clr_en   (rf.we),
      .clr_addr (rf.waddr),
      .busy     (busy)
   );

   // Storage: single write port, register 0 never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            mem[i] <= '0;
      end else if (wr_ok) begin
         mem[rf.waddr] <= rf.wdata;
      end
   end

   // Per-port address decode and same-cycle write/issue matches.
   always_comb begin
      for (int k = 0; k < NRD; k++) begin
         ra[k]      = AW'(port_slice(MAXBUS'(rf.raddr), k, AW));
         fwd_hit[k] = (FWD != 0) && rf.we &&
                      (rf.waddr == ra[k]);
         reiss[k]   = rf.iss_valid &&
                      (rf.iss_addr == ra[k]);
      end
   end

   // Read muxes and busy lookup; a forwarded write hides the hazard
   // unless a new producer is issuing to the same register.
   always_comb begin
      rdata_c = '0;
      rbusy_c = '0;
      for (int k = 0; k < NRD; k++) begin
         if (ra[k] != AW'(ZERO_REG)) begin
            if (fwd_hit[k])
               rdata_c[k*DW +: DW] = rf.wdata;
            else
               rdata_c[k*DW +: DW] = mem[ra[k]];
            rbusy_c[k] = busy[ra[k]] &&
                         !(fwd_hit[k] && !reiss[k]);
         end
      end
   end

   assign rf.rdata  = rdata_c;
   assign rf.rbusy  = rbusy_c;
   assign rf.hazard = |(rf.ren & rbusy_c);

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd: default, no-forwarding and 16x4 builds.
// Expected values are hand-computed constants per step.
module tb_regfile_fwd;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   regfile_fwd_if #(.DW(32), .AW(5), .NRD(2)) a ();
   regfile_fwd_if #(.DW(32), .AW(5), .NRD(2)) n ();
   regfile_fwd_if #(.DW(32), .AW(4), .NRD(4)) p ();

   regfile_fwd #(
      .DW(32), .NREG(32), .NRD(2), .FWD(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .rf  (a.slave)
   );

   regfile_fwd #(
      .DW(32), .NREG(32), .NRD(2), .FWD(0)
   ) dut_nf (
      .clk (clk),
      .rst (rst),
      .rf  (n.slave)
   );

   regfile_fwd #(
      .DW(32), .NREG(16), .NRD(4), .FWD(1)
   ) dut_p (
      .clk (clk),
      .rst (rst),
      .rf  (p.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      a.raddr = '0; a.ren = '0; a.we = 1'b0; a.waddr = '0;
      a.wdata = '0; a.iss_valid = 1'b0; a.iss_addr = '0;
      n.raddr = '0; n.ren = '0; n.we = 1'b0; n.waddr = '0;
      n.wdata = '0; n.iss_valid = 1'b0; n.iss_addr = '0;
      p.raddr = '0; p.ren = '0; p.we = 1'b0; p.waddr = '0;
      p.wdata = '0; p.iss_valid = 1'b0; p.iss_addr = '0;

      // Power-on reset state.
      a.raddr = {5'd2, 5'd1};
      a.ren = 2'b11;
      #2;
      chk("por_rdata", a.rdata, 0);
      chk("por_rbusy", a.rbusy, 0);
      chk("por_hazard", a.hazard, 0);
      tick();
      tick();
      rst = 1'b0;

      // Write r5, mark r5 busy, then reset mid-cycle.
      a.we = 1'b1; a.waddr = 5'd5; a.wdata = 32'hDEADBEEF;
      tick();
      a.we = 1'b0;
      a.iss_valid = 1'b1; a.iss_addr = 5'd5;
      tick();
      a.iss_valid = 1'b0;
      a.raddr = {5'd0, 5'd5};
      a.ren = 2'b01;
      #1;
      chk("pre_rst_r5", a.rdata[31:0], 32'hDEADBEEF);
      chk("pre_rst_busy", a.rbusy[0], 1'b1);
      chk("pre_rst_haz", a.hazard, 1'b1);
      a.we = 1'b1; a.waddr = 5'd6; a.wdata = 32'h66666666;
      #1;
      rst = 1'b1;
      #1;
      chk("rst_r5", a.rdata[31:0], 0);
      chk("rst_rbusy", a.rbusy, 0);
      chk("rst_hazard", a.hazard, 0);
      tick();
      a.we = 1'b0;
      rst = 1'b0;
      a.raddr = {5'd6, 5'd5};
      #1;
      chk("post_rst_r5", a.rdata[31:0], 0);
      chk("post_rst_r6", a.rdata[63:32], 0);

      // Write then read; r0 ignores writes.
      a.ren = 2'b00;
      a.we = 1'b1; a.waddr = 5'd3; a.wdata = 32'h12345678;
      tick();
      a.we = 1'b0;
      a.raddr = {5'd0, 5'd3};
      #1;
      chk("wr_rd_r3", a.rdata[31:0], 32'h12345678);
      chk("wr_rd_r0", a.rdata[63:32], 0);
      a.we = 1'b1; a.waddr = 5'd0; a.wdata = 32'hFFFFFFFF;
      a.raddr = {5'd3, 5'd0};
      #1;
      chk("r0_fwd", a.rdata[31:0], 0);
      tick();
      a.we = 1'b0;
      #1;
      chk("r0_stored", a.rdata[31:0], 0);
      chk("r3_port1", a.rdata[63:32], 32'h12345678);

      // Same-cycle forwarding with FWD=1.
      a.we = 1'b1; a.waddr = 5'd7; a.wdata = 32'hA5A5A5A5;
      a.raddr = {5'd0, 5'd7};
      #1;
      chk("fwd_r7", a.rdata[31:0], 32'hA5A5A5A5);
      tick();
      a.we = 1'b0;
      #1;
      chk("fwd_r7_next", a.rdata[31:0], 32'hA5A5A5A5);

      // No forwarding with FWD=0.
      n.we = 1'b1; n.waddr = 5'd7; n.wdata = 32'hA5A5A5A5;
      n.raddr = {5'd0, 5'd7};
      #1;
      chk("nf_r7_old", n.rdata[31:0], 0);
      tick();
      n.we = 1'b0;
      #1;
      chk("nf_r7_new", n.rdata[31:0], 32'hA5A5A5A5);
      n.iss_valid = 1'b1; n.iss_addr = 5'd8;
      tick();
      n.iss_valid = 1'b0;
      n.we = 1'b1; n.waddr = 5'd8; n.wdata = 32'h8;
      n.raddr = {5'd0, 5'd8};
      n.ren = 2'b01;
      #1;
      chk("nf_busy_raw", n.rbusy[0], 1'b1);
      chk("nf_hazard", n.hazard, 1'b1);
      chk("nf_r8_old", n.rdata[31:0], 0);
      tick();
      n.we = 1'b0;
      #1;
      chk("nf_busy_clr", n.rbusy[0], 1'b0);
      chk("nf_r8_new", n.rdata[31:0], 32'h8);

      // Scoreboard set, hazard gating, forwarded release.
      a.iss_valid = 1'b1; a.iss_addr = 5'd9;
      tick();
      a.iss_valid = 1'b0;
      a.raddr = {5'd0, 5'd9};
      a.ren = 2'b01;
      #1;
      chk("sb_busy9", a.rbusy[0], 1'b1);
      chk("sb_haz9", a.hazard, 1'b1);
      a.ren = 2'b00;
      #1;
      chk("sb_ren_off", a.hazard, 1'b0);
      chk("sb_busy_kept", a.rbusy[0], 1'b1);
      a.ren = 2'b01;
      a.we = 1'b1; a.waddr = 5'd9; a.wdata = 32'h99;
      #1;
      chk("sb_fwd_rbusy", a.rbusy[0], 1'b0);
      chk("sb_fwd_haz", a.hazard, 1'b0);
      chk("sb_fwd_data", a.rdata[31:0], 32'h99);
      tick();
      a.we = 1'b0;
      #1;
      chk("sb_cleared", a.rbusy[0], 1'b0);

      // Set/clear collision on r4.
      a.we = 1'b1; a.waddr = 5'd4; a.wdata = 32'h44444444;
      a.iss_valid = 1'b1; a.iss_addr = 5'd4;
      a.raddr = {5'd0, 5'd4};
      tick();
      a.we = 1'b0;
      a.iss_valid = 1'b0;
      #1;
      chk("col_busy", a.rbusy[0], 1'b1);
      chk("col_data", a.rdata[31:0], 32'h44444444);
      a.we = 1'b1; a.waddr = 5'd4; a.wdata = 32'h55;
      a.iss_valid = 1'b1; a.iss_addr = 5'd4;
      #1;
      chk("col_reiss_busy", a.rbusy[0], 1'b1);
      tick();
      a.iss_valid = 1'b0;
      #1;
      chk("col_retire_fwd", a.rbusy[0], 1'b0);
      tick();
      a.we = 1'b0;
      #1;
      chk("col_retired", a.rbusy[0], 1'b0);
      chk("col_final", a.rdata[31:0], 32'h55);

      // Issue to r0 is ignored.
      a.iss_valid = 1'b1; a.iss_addr = 5'd0;
      a.raddr = {5'd0, 5'd0};
      a.ren = 2'b11;
      tick();
      a.iss_valid = 1'b0;
      #1;
      chk("r0_busy", a.rbusy, 0);
      chk("r0_hazard", a.hazard, 0);

      // 16-register, 4-port build.
      p.we = 1'b1; p.waddr = 4'd1; p.wdata = 32'd1;
      tick();
      p.waddr = 4'd2; p.wdata = 32'd2;
      tick();
      p.waddr = 4'd15; p.wdata = 32'd15;
      tick();
      p.we = 1'b0;
      p.raddr = {4'd0, 4'd15, 4'd2, 4'd1};
      #1;
      chk("p_port0", p.rdata[31:0], 32'd1);
      chk("p_port1", p.rdata[63:32], 32'd2);
      chk("p_port2", p.rdata[95:64], 32'd15);
      chk("p_port3", p.rdata[127:96], 32'd0);
      p.raddr = {4'd1, 4'd0, 4'd15, 4'd2};
      #1;
      chk("p_swap", p.rdata,
          {32'd1, 32'd0, 32'd15, 32'd2});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_fwd.md
Name: regfile_fwd

Overview:
- Parametrised successor to the single-cycle CPU register file, for the pipelined core.
- Provides NRD combinational read ports and one synchronous write port, with write-to-read forwarding and a per-register busy scoreboard for RAW hazard detection.
- Sits between decode (reads and issue) and writeback (write and busy release).
- The writeback data mux stays outside this block.

Parameters:
- DW, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, at least 2
- AW, $clog2(NREG), register address width; derived, never overridden
- NRD, 2, number of read ports, 1..4
- FWD, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = no forwarding

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- raddr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- ren  in  NRD  read-port valid; gates hazard reporting only
- rdata  out  NRD*DW  read data; port k uses bits [k*DW +: DW]
- rbusy  out  NRD  port k's source register has a pending producer
- hazard  out  1  OR over k of (ren[k] & rbusy[k])
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  DW  write data
- iss_valid  in  1  an instruction with a destination register issues this cycle
- iss_addr  in  AW  destination of the issuing instruction

Behaviour:
- Reset, asynchronous on rst high:
  - all NREG registers clear to 0 and all busy bits clear.
  - outputs are combinational from state, so during reset rdata = 0, rbusy = 0, hazard = 0.
  - Reset asserted mid-operation discards any pending write in that cycle.
- Register 0:
  - always reads 0 and is never written.
  - never marked busy: an issue to address 0 is ignored.
- Read, combinational, zero latency:
  - If raddr_k == 0: rdata_k = 0.
  - Else if FWD and we and waddr == raddr_k: rdata_k = wdata.
  - Else: rdata_k = stored value.
- Write:
  - On posedge clk, if we and waddr != 0: register[waddr] <= wdata.
  - The written value is visible from the storage the next cycle.
- Scoreboard, per-register busy bit, updated on posedge clk:
  - set when iss_valid and iss_addr != 0.
  - clear when we and waddr != 0.
  - If both hit the same register in the same cycle, set wins: a new producer has issued after the retiring one.
  - Issue to a register that is already busy: the bit stays set. There is no producer count, and the pipeline guarantees in-order writeback.
- rbusy_k, combinational:
  - busy[raddr_k], except 0 when raddr_k == 0.
  - also 0 when FWD and we and waddr == raddr_k and busy is not being re-set by an issue this same cycle. The value is forwarded, so there is no hazard.
  - With FWD = 0, rbusy_k reflects busy[raddr_k] unmodified.
- hazard: pure combinational OR; ports with ren[k] = 0 never contribute.
- Arithmetic: no arithmetic. Addresses must be below NREG (guaranteed when NREG = 2^AW).
- No handshake back-pressure: writes and issues are always accepted.

Decomposition:
- Package rf_pkg holds:
  - default DW/NREG constants
  - the helper function that extracts port k address/data slices
  - the ZERO_REG localparam (0)
- Sub-module rf_scoreboard holds the NREG-bit busy vector plus its set/clear/priority logic. It exposes a busy bit-vector, and regfile_fwd does the per-port lookup and forwarding masks.
- Storage and read muxing stay in regfile_fwd.

Test Plan:
- Reset:
  - Stimulus: write 0xDEADBEEF to r5; assert rst asynchronously mid-cycle; release; read r5.
  - Required: r5 reads 0, rbusy = 0, hazard = 0 immediately on rst assertion.
- Write then read:
  - Stimulus: we=1, waddr=3, wdata=0x12345678; next cycle raddr port0=3, port1=0.
  - Required: rdata0 = 0x12345678, rdata1 = 0.
  - Also write to r0 with 0xFFFFFFFF; r0 still reads 0.
- Forwarding:
  - Stimulus (FWD=1): same cycle we=1, waddr=7, wdata=0xA5A5A5A5, raddr0=7.
  - Required: rdata0 = 0xA5A5A5A5 combinationally in that cycle.
  - Repeat with FWD=0: old value returned, and the new value appears the next cycle.
- Scoreboard:
  - Stimulus: iss_valid, iss_addr=9; next cycle raddr0=9, ren0=1.
  - Required: rbusy0 = 1, hazard = 1.
  - Then ren0=0: hazard = 0.
  - Then we=1, waddr=9 (FWD=1): rbusy0 = 0 in that cycle; busy cleared the following cycle.
- Set/clear collision:
  - Stimulus: same cycle we=1, waddr=4 and iss_valid, iss_addr=4.
  - Required: r4 is still busy next cycle; r4 holds the new wdata.
  - Also iss_addr=0: no busy bit set, rbusy stays 0 for raddr=0.
- Parametric sweep:
  - Stimulus: NREG=16, NRD=4; four simultaneous reads of r1, r2, r15, r0 after writing 1, 2, 15.
  - Required: outputs are 1, 2, 15, 0 on the correct slices.
